// File: rtl/systolic_pkg.sv
// Shared types and arithmetic helpers for the systolic MAC array.
//   pe_state_e : PE control state (IDLE, ACCUM)
//   sat_add    : add with overflow detect and optional clamping; returns {overflow, result}
package systolic_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ACC_W_DEF  = 40;
    localparam int unsigned CNT_W_DEF  = 16;
    // Widest accumulator the helper supports; narrower ones are left-aligned into it.
    localparam int unsigned SUM_W      = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pe_state_e;

    // Operands are left-aligned in SUM_W bits (low bits zero), so the SUM_W+1 sum
    // overflows exactly when the narrower ACC_W+1 sum would, and clamp values shift
    // back down to the correct ACC_W max/min.
    function automatic logic [SUM_W:0] sat_add(
        input logic [SUM_W-1:0] acc,
        input logic [SUM_W-1:0] prod,
        input logic             is_signed,
        input logic             saturate
    );
        logic [SUM_W:0]   sum;
        logic             ovf;
        logic [SUM_W-1:0] res;
        if (is_signed) begin
            sum = {acc[SUM_W-1], acc} + {prod[SUM_W-1], prod};
            ovf = sum[SUM_W] ^ sum[SUM_W-1];
        end else begin
            sum = {1'b0, acc} + {1'b0, prod};
            ovf = sum[SUM_W];
        end
        res = sum[SUM_W-1:0];
        if (ovf && saturate) begin
            if (!is_signed) begin
                res = '1;
            end else if (sum[SUM_W]) begin
                res = {1'b1, {(SUM_W-1){1'b0}}};
            end else begin
                res = {1'b0, {(SUM_W-1){1'b1}}};
            end
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/systolic_mac_pe_drain.sv
// Drain register with valid: parallel capture has priority over a shift from upstream.
//   capture/capture_data : load local result, mark valid
//   shift/shift_data/shift_valid : take upstream data and valid
//   data/valid           : registered drain output
module pe_drain_reg #(
    parameter int unsigned W = 40
) (
    input  logic         clock,
    input  logic         nreset,
    input  logic         capture,
    input  logic [W-1:0] capture_data,
    input  logic         shift,
    input  logic [W-1:0] shift_data,
    input  logic         shift_valid,
    output logic [W-1:0] data,
    output logic         valid
);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (capture) begin
            data  <= capture_data;
            valid <= 1'b1;
        end else if (shift) begin
            data  <= shift_data;
            valid <= shift_valid;
        end
    end

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic PE: forwards a east / b south, accumulates a*b,
// and exposes a drain register for column-wise result readout.
//   a_i/a_valid_i, b_i/b_valid_i     : operands in; a_o/b_o forwarded one cycle later
//   clear_i                          : start new tile (a same-cycle MAC loads first term)
//   drain_i / drain_shift_i          : capture pre-update acc / shift drain chain
//   drain_in_i/drain_valid_i         : upstream drain chain
//   acc_o, mac_count_o, overflow_o, busy_o : live accumulator status
module systolic_mac_pe
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter bit          SIGNED   = 1'b1,
    parameter bit          SATURATE = 1'b1,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic [DATA_W-1:0] a_i,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              b_valid_i,
    output logic [DATA_W-1:0] a_o,
    output logic              a_valid_o,
    output logic [DATA_W-1:0] b_o,
    output logic              b_valid_o,
    input  logic              clear_i,
    input  logic              drain_i,
    input  logic              drain_shift_i,
    input  logic [ACC_W-1:0]  drain_in_i,
    input  logic              drain_valid_i,
    output logic [ACC_W-1:0]  drain_o,
    output logic              drain_valid_o,
    output logic [ACC_W-1:0]  acc_o,
    output logic [CNT_W-1:0]  mac_count_o,
    output logic              overflow_o,
    output logic              busy_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ALIGN  = SUM_W - ACC_W;

    pe_state_e        state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             busy_q;
    logic             mac;
    logic [ACC_W-1:0] prod_ext;
    logic [SUM_W:0]   add_res;
    logic [ACC_W-1:0] sum_acc;
    logic             sum_ovf;

    assign mac = a_valid_i && b_valid_i;

    // Full-width product, extended to the accumulator width per operand signedness.
    if (SIGNED) begin : g_signed
        logic signed [PROD_W-1:0] a_ext, b_ext, prod;
        assign a_ext    = PROD_W'($signed(a_i));
        assign b_ext    = PROD_W'($signed(b_i));
        assign prod     = a_ext * b_ext;
        assign prod_ext = ACC_W'(prod);
    end else begin : g_unsigned
        logic [PROD_W-1:0] a_ext, b_ext, prod;
        assign a_ext    = PROD_W'(a_i);
        assign b_ext    = PROD_W'(b_i);
        assign prod     = a_ext * b_ext;
        assign prod_ext = ACC_W'(prod);
    end

    assign add_res = sat_add(SUM_W'(acc_q) << ALIGN, SUM_W'(prod_ext) << ALIGN,
                             SIGNED, SATURATE);
    assign sum_acc = ACC_W'(add_res[SUM_W-1:0] >> ALIGN);
    assign sum_ovf = add_res[SUM_W];

    // State, accumulator, counter and overflow registers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d == ACCUM);
        end
    end

    // Next-state and datapath update; clear with a MAC loads the first term directly.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE:    if (mac) state_d = ACCUM;
            ACCUM:   if (clear_i && !mac) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            acc_d = mac ? prod_ext : '0;
            cnt_d = mac ? CNT_W'(1) : '0;
            ovf_d = 1'b0;
        end else if (mac) begin
            acc_d = sum_acc;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            ovf_d = ovf_q | sum_ovf;
        end
    end

    // Operand forwarding; data registers load every cycle.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            a_o       <= '0;
            a_valid_o <= 1'b0;
            b_o       <= '0;
            b_valid_o <= 1'b0;
        end else begin
            a_o       <= a_i;
            a_valid_o <= a_valid_i;
            b_o       <= b_i;
            b_valid_o <= b_valid_i;
        end
    end

    // Drain captures acc_q, the value before any same-cycle MAC or clear.
    pe_drain_reg #(.W(ACC_W)) u_drain (
        .clock        (clock),
        .nreset       (nreset),
        .capture      (drain_i),
        .capture_data (acc_q),
        .shift        (drain_shift_i),
        .shift_data   (drain_in_i),
        .shift_valid  (drain_valid_i),
        .data         (drain_o),
        .valid        (drain_valid_o)
    );

    assign acc_o       = acc_q;
    assign mac_count_o = cnt_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Self-checking bench: five PEs with different parameters; a reference model
// pushes expected outputs when stimulus is driven, popped after the clock edge.
//   pe0: signed/sat/40 (bottom of chain), pe1: signed/sat/40 (top of chain)
//   pe2: signed/sat/32, pe3: signed/wrap/32, pe4: unsigned/sat/40
module tb_systolic_mac_pe;

    localparam int N = 5;

    function automatic int aw_of(input int k);
        return (k == 2 || k == 3) ? 32 : 40;
    endfunction
    function automatic bit sg_of(input int k);
        return (k != 4);
    endfunction
    function automatic bit st_of(input int k);
        return (k != 3);
    endfunction

    logic clock = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] a_x [N];
    logic        av_x [N];
    logic [15:0] b_x [N];
    logic        bv_x [N];
    logic        clr_x [N];
    logic        drn_i_x [N];
    logic        dsh_x [N];
    logic [39:0] top_din;
    logic        top_dv;

    logic [15:0] ao_x [N];
    logic        avo_x [N];
    logic [15:0] bo_x [N];
    logic        bvo_x [N];
    logic [63:0] drn_x [N];
    logic        dvo_x [N];
    logic [63:0] acc_x [N];
    logic [15:0] cnt_x [N];
    logic        ovf_x [N];
    logic        busy_x [N];

    for (genvar k = 0; k < N; k++) begin : g_pe
        localparam int unsigned AW = aw_of(k);
        localparam bit SG = sg_of(k);
        localparam bit ST = st_of(k);
        logic [AW-1:0] din_l, drn_l, acc_l;
        logic          dvin_l;
        assign din_l  = (k == 0) ? AW'(drn_x[1]) : AW'(top_din);
        assign dvin_l = (k == 0) ? dvo_x[1] : top_dv;
        systolic_mac_pe #(
            .DATA_W(16), .ACC_W(AW), .SIGNED(SG), .SATURATE(ST), .CNT_W(16)
        ) u_pe (
            .clock         (clock),
            .nreset        (nreset),
            .a_i           (a_x[k]),
            .a_valid_i     (av_x[k]),
            .b_i           (b_x[k]),
            .b_valid_i     (bv_x[k]),
            .a_o           (ao_x[k]),
            .a_valid_o     (avo_x[k]),
            .b_o           (bo_x[k]),
            .b_valid_o     (bvo_x[k]),
            .clear_i       (clr_x[k]),
            .drain_i       (drn_i_x[k]),
            .drain_shift_i (dsh_x[k]),
            .drain_in_i    (din_l),
            .drain_valid_i (dvin_l),
            .drain_o       (drn_l),
            .drain_valid_o (dvo_x[k]),
            .acc_o         (acc_l),
            .mac_count_o   (cnt_x[k]),
            .overflow_o    (ovf_x[k]),
            .busy_o        (busy_x[k])
        );
        assign drn_x[k] = 64'(drn_l);
        assign acc_x[k] = 64'(acc_l);
    end

    typedef struct {
        int          k;
        logic [63:0] acc;
        logic [63:0] cnt;
        logic        ovf;
        logic        busy;
        logic [63:0] a;
        logic        av;
        logic [63:0] b;
        logic        bv;
        logic [63:0] drn;
        logic        dv;
    } exp_t;

    exp_t  sb_q [$];
    string tag_q [$];

    longint m_acc [N];
    int     m_cnt [N];
    bit     m_ovf [N];
    bit     m_busy [N];
    longint m_drn [N];
    bit     m_dv [N];

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < N; k++) begin
            a_x[k] = '0; av_x[k] = 1'b0; b_x[k] = '0; bv_x[k] = 1'b0;
            clr_x[k] = 1'b0; drn_i_x[k] = 1'b0; dsh_x[k] = 1'b0;
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < N; k++) begin
            m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
            m_busy[k] = 1'b0; m_drn[k] = 0; m_dv[k] = 1'b0;
        end
    endtask

    // Drive one PE's inputs for the next edge and push the expected outcome.
    // When several PEs are driven in one cycle, drive pe0 before pe1.
    task automatic drive(input int k, input logic [15:0] a, input bit av,
                         input logic [15:0] b, input bit bv, input bit clr,
                         input bit drn, input bit dsh, input string tag);
        exp_t   e;
        longint prod, sum, mx, mn, mask, w;
        bit     mac, sg;
        int     aw;
        aw   = aw_of(k);
        sg   = sg_of(k);
        mask = (longint'(1) << aw) - 1;
        mx   = sg ? (longint'(1) << (aw - 1)) - 1 : mask;
        mn   = sg ? -(longint'(1) << (aw - 1)) : 0;
        a_x[k] = a; av_x[k] = av; b_x[k] = b; bv_x[k] = bv;
        clr_x[k] = clr; drn_i_x[k] = drn; dsh_x[k] = dsh;
        mac = av && bv;
        if (sg) prod = longint'($signed(a)) * longint'($signed(b));
        else    prod = longint'(a) * longint'(b);
        if (drn) begin
            m_drn[k] = m_acc[k] & mask;
            m_dv[k]  = 1'b1;
        end else if (dsh) begin
            if (k == 0) begin
                m_drn[0] = m_drn[1];
                m_dv[0]  = m_dv[1];
            end else begin
                m_drn[k] = longint'(top_din) & mask;
                m_dv[k]  = top_dv;
            end
        end
        if (clr) begin
            m_acc[k] = mac ? prod : 0;
            m_cnt[k] = mac ? 1 : 0;
            m_ovf[k] = 1'b0;
        end else if (mac) begin
            sum = m_acc[k] + prod;
            if (sum > mx || sum < mn) begin
                m_ovf[k] = 1'b1;
                if (st_of(k)) begin
                    sum = (sum > mx) ? mx : mn;
                end else begin
                    w = sum & mask;
                    if (sg && w > mx) w -= mask + 1;
                    sum = w;
                end
            end
            m_acc[k] = sum;
            if (m_cnt[k] != 32'hFFFF) m_cnt[k]++;
        end
        if (mac)      m_busy[k] = 1'b1;
        else if (clr) m_busy[k] = 1'b0;
        e.k = k;
        e.acc = 64'(m_acc[k] & mask);
        e.cnt = 64'(m_cnt[k]);
        e.ovf = m_ovf[k];
        e.busy = m_busy[k];
        e.a = 64'(a); e.av = av; e.b = 64'(b); e.bv = bv;
        e.drn = 64'(m_drn[k]);
        e.dv = m_dv[k];
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Advance one edge, then compare every pending expectation.
    task automatic tick();
        exp_t  e;
        string t;
        @(posedge clock);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check_eq({t, ".acc"},   acc_x[e.k],         e.acc);
            check_eq({t, ".cnt"},   64'(cnt_x[e.k]),    e.cnt);
            check_eq({t, ".ovf"},   64'(ovf_x[e.k]),    64'(e.ovf));
            check_eq({t, ".busy"},  64'(busy_x[e.k]),   64'(e.busy));
            check_eq({t, ".a_o"},   64'(ao_x[e.k]),     e.a);
            check_eq({t, ".a_vo"},  64'(avo_x[e.k]),    64'(e.av));
            check_eq({t, ".b_o"},   64'(bo_x[e.k]),     e.b);
            check_eq({t, ".b_vo"},  64'(bvo_x[e.k]),    64'(e.bv));
            check_eq({t, ".drain"}, drn_x[e.k],         e.drn);
            check_eq({t, ".dvo"},   64'(dvo_x[e.k]),    64'(e.dv));
        end
        idle_inputs();
    endtask

    task automatic check_zero(input int k, input string tag);
        check_eq({tag, ".acc"},   acc_x[k],          64'd0);
        check_eq({tag, ".cnt"},   64'(cnt_x[k]),     64'd0);
        check_eq({tag, ".ovf"},   64'(ovf_x[k]),     64'd0);
        check_eq({tag, ".busy"},  64'(busy_x[k]),    64'd0);
        check_eq({tag, ".a_o"},   64'(ao_x[k]),      64'd0);
        check_eq({tag, ".a_vo"},  64'(avo_x[k]),     64'd0);
        check_eq({tag, ".b_o"},   64'(bo_x[k]),      64'd0);
        check_eq({tag, ".b_vo"},  64'(bvo_x[k]),     64'd0);
        check_eq({tag, ".drain"}, drn_x[k],          64'd0);
        check_eq({tag, ".dvo"},   64'(dvo_x[k]),     64'd0);
    endtask

    initial begin
        top_din = '0;
        top_dv  = 1'b0;
        idle_inputs();
        reset_model();
        nreset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < N; k++) check_zero(k, $sformatf("rst%0d", k));
        nreset = 1'b1;
        @(posedge clock);
        #1;

        // Signed accumulate: 12, 2, 51.
        drive(0, 16'd3, 1, 16'd4, 1, 0, 0, 0, "mac1"); tick();
        drive(0, 16'(-2), 1, 16'd5, 1, 0, 0, 0, "mac2"); tick();
        drive(0, 16'd7, 1, 16'd7, 1, 0, 0, 0, "mac3"); tick();

        // Forwarding with only a valid: acc holds.
        drive(0, 16'h1234, 1, 16'h0000, 0, 0, 0, 0, "fwd"); tick();

        // Saturating and wrapping 32-bit accumulators.
        for (int i = 0; i < 4; i++) begin
            drive(2, 16'd32767, 1, 16'd32767, 1, 0, 0, 0, $sformatf("sat%0d", i));
            drive(3, 16'd32767, 1, 16'd32767, 1, 0, 0, 0, $sformatf("wrap%0d", i));
            tick();
        end
        drive(2, 16'd0, 0, 16'd0, 0, 1, 0, 0, "satclr");
        drive(3, 16'd0, 0, 16'd0, 0, 1, 0, 0, "wrapclr");
        tick();

        // Tile handoff: drain old result while loading first term of the next tile.
        drive(0, 16'd2, 1, 16'd3, 1, 1, 1, 0, "handoff"); tick();

        // Drain chain: pe0 = 20 (bottom), pe1 = 10 (top).
        drive(0, 16'd4, 1, 16'd5, 1, 1, 0, 0, "ch_ld0");
        drive(1, 16'd2, 1, 16'd5, 1, 0, 0, 0, "ch_ld1");
        tick();
        top_din = 40'hABC;
        top_dv  = 1'b0;
        drive(0, 16'd0, 0, 16'd0, 0, 0, 1, 0, "ch_cap0");
        drive(1, 16'd0, 0, 16'd0, 0, 0, 1, 0, "ch_cap1");
        tick();
        drive(0, 16'd0, 0, 16'd0, 0, 0, 0, 1, "ch_sh0a");
        drive(1, 16'd0, 0, 16'd0, 0, 0, 0, 1, "ch_sh1a");
        tick();
        drive(0, 16'd0, 0, 16'd0, 0, 0, 0, 1, "ch_sh0b");
        tick();
        drive(0, 16'd0, 0, 16'd0, 0, 0, 0, 0, "ch_hold");
        tick();

        // Unsigned product, then asynchronous reset mid-tile.
        drive(4, 16'hFFFF, 1, 16'hFFFF, 1, 0, 0, 0, "uns"); tick();
        drive(4, 16'h0001, 1, 16'h0002, 1, 0, 0, 0, "uns2");
        #2;
        nreset = 1'b0;
        #1;
        check_zero(4, "arst4");
        check_zero(0, "arst0");
        reset_model();
        sb_q.delete();
        tag_q.delete();
        idle_inputs();
        @(posedge clock);
        #1;
        nreset = 1'b1;
        @(posedge clock);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
